// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated word RAM serving load/store requests with an error flag; byte strobes optional via MEM_BYTE_STROBE_EN
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
`ifdef MEM_BYTE_STROBE_EN
    input  logic [3:0]  be_i,
`endif
    output logic        ready_o,
    output logic        ack_o,
    output logic        err_o,
    output logic [31:0] read_data_o
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t                r_state, w_state_nxt;
    logic [7:0]            r_cnt;
    logic                  r_we, r_err;
    logic [31:0]           r_addr, r_wdata, r_rdata;
    logic [3:0]            r_be, w_be;
    logic [31:0]           r_mem [2**ADDR_WIDTH];
    logic                  w_illegal, w_done;
    logic [ADDR_WIDTH-1:0] w_idx;
`ifdef MEM_BYTE_STROBE_EN
    assign w_be = be_i;
`else
    assign w_be = 4'hF;
`endif
    assign w_idx       = r_addr[ADDR_WIDTH+1:2];
    assign w_illegal   = (r_addr[1:0] != 2'b0) || (r_addr[31:ADDR_WIDTH+2] != '0);
    assign w_done      = (r_state == WAIT) && (r_cnt == 8'd0);
    assign ready_o     = r_state == IDLE;
    assign ack_o       = r_state == RESP;
    assign err_o       = ack_o && r_err;
    assign read_data_o = r_rdata;
    // next state: accept when idle, complete when the wait counter runs out, ack lasts one cycle
    always_comb begin
        w_state_nxt = (r_state == IDLE) ? (req_i ? WAIT : IDLE) :
                      (r_state == WAIT) ? ((r_cnt == 8'd0) ? RESP : WAIT) : IDLE;
    end
    // state, request latch, wait counter and completion results
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && req_i) begin
                r_we    <= we_i;
                r_addr  <= addr_i;
                r_wdata <= write_data_i;
                r_be    <= w_be;
                r_cnt   <= 8'(WAIT_CYCLES);
            end else if (r_state == WAIT && r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_done) begin
                r_err <= w_illegal;
                if (w_illegal) r_rdata <= '0;
                else if (!r_we) r_rdata <= r_mem[w_idx];
            end
            if (r_state == RESP) r_err <= 1'b0;
        end
    end
    // RAM write at the completion edge; a reset on that edge abandons the store
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_done && r_we && !w_illegal)
            for (int k = 0; k < 4; k++)
                if (r_be[k]) r_mem[w_idx][8*k+:8] <= r_wdata[8*k+:8];
    end
endmodule
